screen_pixel_pipe: RTL



---
 rtl/screen_pixel_pipe_pkg.sv | 41 ++++
 rtl/screen_pixel_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/screen_pixel_pipe_pkg.sv
// screen_pixel_pipe_pkg
//   Shared types, constants and colour-expansion helpers for the screen
//   pixel output stage.
//   - rgb3_t        : one 3-bit DAC channel
//   - rgb_t         : packed {r, g, b} triple
//   - PAL_PAPER_OFS : palette group used for border/paper indexing
//   - up_expand     : ULAplus GGGRRRBB byte -> r/g/b
//   - zx_expand     : classic ZX {G,R,B} index + BRIGHT -> r/g/b
package screen_pixel_pipe_pkg;

  typedef logic [2:0] rgb3_t;

  typedef struct packed {
    rgb3_t r;
    rgb3_t g;
    rgb3_t b;
  } rgb_t;

  localparam logic [2:0] PAL_PAPER_OFS = 3'b001;

  // Blue has only two bits in GGGRRRBB; the LSB is synthesised as the OR of
  // the two so that full blue reaches 3'b111 and zero stays zero.
  function automatic rgb_t up_expand(input logic [7:0] c);
    rgb_t o;
    o.r = c[4:2];
    o.g = c[7:5];
    o.b = {c[1:0], c[1] | c[0]};
    return o;
  endfunction

  function automatic rgb_t zx_expand(input logic [2:0] idx, input logic bright);
    rgb_t  o;
    rgb3_t lvl;
    lvl = bright ? 3'b111 : 3'b101;
    o.g = idx[2] ? lvl : 3'b000;
    o.r = idx[1] ? lvl : 3'b000;
    o.b = idx[0] ? lvl : 3'b000;
    return o;
  endfunction

endpackage

// File: rtl/screen_pixel_pipe.sv
// screen_pixel_pipe
//   Pixel output stage of the screen path. Shifts fetched bitmap bytes and
//   holds attributes at the 7 MHz pixel rate, drives the ULAplus palette
//   address ports and produces registered r/g/b in ULAplus or classic ZX mode.
//
// Ports
//   clk28       : 28 MHz system clock
//   rst_n       : synchronous active-low reset
//   ck7         : pixel clock enable, one clk28 cycle high every 4
//   load        : with ck7, take new bitmap/attr at this pixel boundary
//   bitmap      : fetched pixel byte, MSB leftmost
//   attr        : {FLASH, BRIGHT, PAPER[2:0], INK[2:0]}
//   blank       : with ck7, current pixel is border
//   border      : border colour index {G,R,B}
//   vsync       : one-cycle pulse per frame, advances the flash counter
//   up_active   : ULAplus mode enable
//   ink_addr    : palette ink index (registered)
//   paper_addr  : palette paper index (registered)
//   ink, paper  : palette colours returned for ink_addr/paper_addr, GGGRRRBB
//   r, g, b     : registered output colour
module screen_pixel_pipe
  import screen_pixel_pipe_pkg::*;
(
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck7,
  input  logic       load,
  input  logic [7:0] bitmap,
  input  logic [7:0] attr,
  input  logic       blank,
  input  logic [2:0] border,
  input  logic       vsync,
  input  logic       up_active,
  output logic [5:0] ink_addr,
  output logic [5:0] paper_addr,
  input  logic [7:0] ink,
  input  logic [7:0] paper,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b
);

  logic [7:0] shreg_p0_q, shreg_p0_d;
  logic [7:0] attr_p0_q,  attr_p0_d;
  logic       blank_p0_q, blank_p0_d;
  logic [4:0] flash_cnt_q, flash_cnt_d;
  logic [5:0] ink_addr_q, ink_addr_d;
  logic [5:0] paper_addr_q, paper_addr_d;
  rgb_t       rgb_p1_q, rgb_p1_d;

  logic       pix_p1_d;
  logic       blank_p1_d;
  logic [7:0] attr_p1_d;
  logic       flash_ph;
  logic       zx_sel;
  rgb_t       colour;

  // Stage 0: shifter, attribute latch and blank flag at the pixel boundary
  always_comb begin
    shreg_p0_d = shreg_p0_q;
    attr_p0_d  = attr_p0_q;
    blank_p0_d = blank_p0_q;
    if (ck7) begin
      blank_p0_d = blank;
      if (load) begin
        shreg_p0_d = bitmap;
        attr_p0_d  = attr;
      end else begin
        shreg_p0_d = {shreg_p0_q[6:0], 1'b0};
      end
    end
  end

  // 5-bit counter wraps naturally; bit 4 toggles every 16 frames.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (vsync) flash_cnt_d = flash_cnt_q + 5'd1;
  end
  assign flash_ph = flash_cnt_q[4];

  // Palette addresses follow the stage-0 registers one clk28 later, giving the
  // palette RAM the remaining three cycles of the pixel to return data. During
  // border the ink port keeps its last address so the RAM sees no churn.
  always_comb begin
    ink_addr_d   = ink_addr_q;
    paper_addr_d = {PAL_PAPER_OFS, border};
    if (!blank_p0_q) begin
      ink_addr_d   = {attr_p0_q[7:6], 1'b0, attr_p0_q[2:0]};
      paper_addr_d = {attr_p0_q[7:6], 1'b1, attr_p0_q[5:3]};
    end
  end

  // Stage 1: colour select for the pixel held in stage 0, registered at the
  // next ck7 so r/g/b lag the load by exactly one pixel (4 clk28).
  assign pix_p1_d   = shreg_p0_q[7];
  assign blank_p1_d = blank_p0_q;
  assign attr_p1_d  = attr_p0_q;
  assign zx_sel     = pix_p1_d ^ (attr_p1_d[7] & flash_ph);

  always_comb begin
    if (up_active) begin
      if (!blank_p1_d && pix_p1_d) colour = up_expand(ink);
      else                         colour = up_expand(paper);
    end else if (blank_p1_d) begin
      colour = zx_expand(border, 1'b0);
    end else begin
      colour = zx_expand(zx_sel ? attr_p1_d[2:0] : attr_p1_d[5:3], attr_p1_d[6]);
    end
  end

  always_comb begin
    rgb_p1_d = rgb_p1_q;
    if (ck7) rgb_p1_d = colour;
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      shreg_p0_q   <= 8'h00;
      attr_p0_q    <= 8'h00;
      blank_p0_q   <= 1'b1;
      flash_cnt_q  <= 5'd0;
      ink_addr_q   <= 6'd0;
      paper_addr_q <= 6'd0;
      rgb_p1_q     <= '0;
    end else begin
      shreg_p0_q   <= shreg_p0_d;
      attr_p0_q    <= attr_p0_d;
      blank_p0_q   <= blank_p0_d;
      flash_cnt_q  <= flash_cnt_d;
      ink_addr_q   <= ink_addr_d;
      paper_addr_q <= paper_addr_d;
      rgb_p1_q     <= rgb_p1_d;
    end
  end

  assign ink_addr   = ink_addr_q;
  assign paper_addr = paper_addr_q;
  assign r          = rgb_p1_q.r;
  assign g          = rgb_p1_q.g;
  assign b          = rgb_p1_q.b;

endmodule
